led_pwm_fader: RTL and testbench
================================

// Module: led_pwm_fader
// PURPOSE
//  Downstream stage of the LED blink sequencer. Consumes its two on/off LED
//  levels (led1/led2) as brightness requests. Drives the physical LED pins
//  with 8-bit PWM, so every on/off edge becomes a linear fade instead of a
//  hard step. Sits between the blink logic and the board LED pins; all inputs
//  are in the same clock domain.
// PARAMETERS
//  PWM_BITS  8      PWM counter / brightness width; one period = 2**PWM_BITS clks
//  RAMP_DIV  97656  clks per brightness step; >=1; full fade ~0.25 s at 100 MHz
// PORTS
//  clk       in   1         system clock (100 MHz)
//  rst       in   1         asynchronous, active-high reset
//  led1_req  in   1         channel 1 target: 1 = full on, 0 = off
//  led2_req  in   1         channel 2 target, same meaning
//  hold      in   1         1 = freeze ramp prescaler (levels held, PWM keeps running)
//  pwm1      out  1         channel 1 PWM pin drive, registered
//  pwm2      out  1         channel 2 PWM pin drive, registered
//  level1    out  PWM_BITS  channel 1 current brightness
//  level2    out  PWM_BITS  channel 2 current brightness
//  state1    out  2         channel 1 FSM: 0=OFF 1=RISE 2=ON 3=FALL
//  state2    out  2         channel 2 FSM, same encoding
//  busy      out  1         registered; 1 while either channel is RISE or FALL
// BEHAVIOUR
//  Reset (async, immediate, no clock edge needed):
//  - pwm_cnt, prescaler, level1/2, pwm1/2, busy = 0; state1/2 = OFF.
//  - Reset mid-fade drops the pins low at once; after release, fades restart from 0.
//  PWM counter:
//  - free-running 0..2**PWM_BITS-1, wraps to 0; never frozen by hold.
//  Prescaler:
//  - counts 0..RAMP_DIV-1, wraps to 0; tick = 1 for one clk at RAMP_DIV-1.
//  - hold=1: prescaler keeps its value and tick = 0.
//  - RAMP_DIV=1: tick every clk unless hold.
//  - width = max(1, $clog2(RAMP_DIV)).
//  Per channel (identical, independent):
//  - MAX = 2**PWM_BITS-1; target = req ? MAX : 0.
//  - On tick: level+1 if level<target, level-1 if level>target, else unchanged.
//    Step is 1 per tick; level never wraps or goes past 0 or MAX.
//  - req is sampled every clk. A reversal mid-ramp (RISE<->FALL) continues from
//    the current level, with no jump.
//  - state <= f(req, next_level), every clk:
//      OFF  if !req && next_level==0     ON   if req && next_level==MAX
//      RISE if req && next_level<MAX     FALL if !req && next_level>0
//  - req edge -> state updates on the next clk edge.
//  - req edge together with tick: the step uses the new req.
//  - pwm <= (level==MAX) ? 1 : (pwm_cnt < level); one clk after level.
//      level 0   -> pwm stays low
//      level MAX -> pwm stays high, no one-clk dip at wrap
//      level L   -> pwm high exactly L clks per period
//  Full fade: MAX ticks = MAX*RAMP_DIV clks, assuming hold stays 0.
//  busy <= (next state1 in {RISE,FALL}) | (next state2 in {RISE,FALL}).
// TESTING  (bench params: PWM_BITS=4, RAMP_DIV=4, MAX=15)
//  1 Assert rst mid-run, no clk edge -> pwm1/2=0, level1/2=0, state1/2=OFF, busy=0
//    immediately.
//  2 led1_req=1 held -> state1=RISE next clk; level1 +1 every 4 clks; reaches 15
//    after 60 clks; state1=ON, busy=0; pwm1 constant 1 over 2 full periods.
//  3 With level1 frozen at 4 (hold=1) -> pwm1 high exactly 4 of every 16 clks.
//    Repeat with level 0 -> 0 of 16.
//  4 Drop led1_req at level1=7 during RISE -> state1=FALL next clk; level1 hits 0
//    after 28 clks; state1=OFF.
//  5 hold=1 for 40 clks mid-rise -> level1 unchanged, pwm keeps toggling;
//    hold=0 -> steps resume on the 4-clk grid from the held prescaler value.
//  6 led1_req and led2_req toggled together with RAMP_DIV=1 -> independent
//    ramps, both reach 15 in 15 clks; busy falls on the same edge as the
//    last RISE->ON change.

Source files
------------

// File: rtl/led_pwm_fader.sv
// Two-channel LED fader: each on/off request becomes a linear brightness ramp,
// and the current brightness drives a free-running PWM output pin.
module led_pwm_fader #(
    parameter int PWM_BITS = 8,
    parameter int RAMP_DIV = 97656
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                led1_req,
    input  logic                led2_req,
    input  logic                hold,
    output logic                pwm1,
    output logic                pwm2,
    output logic [PWM_BITS-1:0] level1,
    output logic [PWM_BITS-1:0] level2,
    output logic [1:0]          state1,
    output logic [1:0]          state2,
    output logic                busy
);

    localparam int PSC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PSC_W-1:0]    PSC_LAST = PSC_W'(RAMP_DIV - 1);
    localparam logic [PWM_BITS-1:0] MAX_LVL  = '1;

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_RISE = 2'd1,
        S_ON   = 2'd2,
        S_FALL = 2'd3
    } state_t;

    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PSC_W-1:0]    presc_q;
    logic [PSC_W-1:0]    presc_d;
    logic                tick;
    logic                busy_q;
    logic                busy_d;

    logic [1:0]          req_w;
    logic [PWM_BITS-1:0] level_w [2];
    logic [1:0]          state_w [2];
    logic [1:0]          pwm_w;
    logic [1:0]          ramp_w;

    assign req_w = {led2_req, led1_req};

    // hold freezes only the ramp timebase; the PWM counter never stops
    always_comb begin
        tick    = !hold && (presc_q == PSC_LAST);
        presc_d = presc_q;
        if (tick) begin
            presc_d = '0;
        end else if (!hold) begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_q <= '0;
            presc_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            presc_q   <= presc_d;
            busy_q    <= busy_d;
        end
    end

    assign busy_d = |ramp_w;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            state_t              state_q;
            state_t              state_d;
            logic [PWM_BITS-1:0] level_q;
            logic [PWM_BITS-1:0] level_d;
            logic                pwm_q;
            logic                pwm_d;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_q <= S_OFF;
                    level_q <= '0;
                    pwm_q   <= 1'b0;
                end else begin
                    state_q <= state_d;
                    level_q <= level_d;
                    pwm_q   <= pwm_d;
                end
            end

            // State is derived from the request and the level after this
            // step, so a reversal mid-ramp just changes direction in place.
            always_comb begin
                level_d = level_q;
                if (tick) begin
                    if (req_w[gi] && (level_q != MAX_LVL)) begin
                        level_d = level_q + 1'b1;
                    end else if (!req_w[gi] && (level_q != '0)) begin
                        level_d = level_q - 1'b1;
                    end
                end
                if (req_w[gi]) begin
                    state_d = (level_d == MAX_LVL) ? S_ON : S_RISE;
                end else begin
                    state_d = (level_d == '0) ? S_OFF : S_FALL;
                end
            end

            // Full brightness is forced high so the pin never dips at wrap.
            always_comb begin
                pwm_d      = (level_q == MAX_LVL) || (pwm_cnt_q < level_q);
                ramp_w[gi] = (state_d == S_RISE) || (state_d == S_FALL);
            end

            assign level_w[gi] = level_q;
            assign state_w[gi] = state_q;
            assign pwm_w[gi]   = pwm_q;
        end
    endgenerate

    assign pwm1   = pwm_w[0];
    assign pwm2   = pwm_w[1];
    assign level1 = level_w[0];
    assign level2 = level_w[1];
    assign state1 = state_w[0];
    assign state2 = state_w[1];
    assign busy   = busy_q;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Bench for led_pwm_fader: cycle scoreboard against a behavioural model, a
// table of ramp milestones, and hand-written hold/reset/PWM-duty sequences.
module tb_led_pwm_fader;

    localparam int OFF  = 0;
    localparam int RISE = 1;
    localparam int ON   = 2;
    localparam int FALL = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       led1_req = 1'b0, led2_req = 1'b0, hold = 1'b0;
    logic       pwm1, pwm2, busy;
    logic [3:0] level1, level2;
    logic [1:0] state1, state2;

    logic       b_req1 = 1'b0, b_req2 = 1'b0;
    logic       b_pwm1, b_pwm2, b_busy;
    logic [3:0] b_level1, b_level2;
    logic [1:0] b_state1, b_state2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    led_pwm_fader #(.PWM_BITS(4), .RAMP_DIV(4)) dut_a (
        .clk(clk), .rst(rst), .led1_req(led1_req), .led2_req(led2_req), .hold(hold),
        .pwm1(pwm1), .pwm2(pwm2), .level1(level1), .level2(level2),
        .state1(state1), .state2(state2), .busy(busy)
    );

    led_pwm_fader #(.PWM_BITS(4), .RAMP_DIV(1)) dut_b (
        .clk(clk), .rst(rst), .led1_req(b_req1), .led2_req(b_req2), .hold(1'b0),
        .pwm1(b_pwm1), .pwm2(b_pwm2), .level1(b_level1), .level2(b_level2),
        .state1(b_state1), .state2(b_state2), .busy(b_busy)
    );

    typedef struct packed {
        logic       pwm1;
        logic       pwm2;
        logic [3:0] level1;
        logic [3:0] level2;
        logic [1:0] state1;
        logic [1:0] state2;
        logic       busy;
    } obs_t;

    typedef struct {
        int n;
        bit r1;
        bit r2;
        bit h;
        int lvl;
        int st;
        int bsy;
    } vec_t;

    obs_t sb_q[$];

    int m_cnt, m_presc;
    int m_lvl [2];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_presc = 0;
        m_lvl[0] = 0;
        m_lvl[1] = 0;
        sb_q.delete();
    endtask

    // Drive one cycle on dut_a, push the model's prediction, then compare.
    task automatic tick_a(input bit r1, input bit r2, input bit h);
        obs_t e, got;
        bit   rq [2];
        int   nl [2];
        int   st [2];
        bit   pw [2];
        bit   tk;
        led1_req = r1;
        led2_req = r2;
        hold = h;
        rq[0] = r1;
        rq[1] = r2;
        tk = !h && (m_presc == 3);
        for (int c = 0; c < 2; c++) begin
            pw[c] = (m_lvl[c] == 15) || (m_cnt < m_lvl[c]);
            nl[c] = m_lvl[c];
            if (tk && rq[c] && m_lvl[c] < 15) nl[c] = m_lvl[c] + 1;
            if (tk && !rq[c] && m_lvl[c] > 0) nl[c] = m_lvl[c] - 1;
            if (rq[c]) st[c] = (nl[c] == 15) ? ON : RISE;
            else       st[c] = (nl[c] == 0) ? OFF : FALL;
        end
        e.pwm1 = pw[0];
        e.pwm2 = pw[1];
        e.level1 = 4'(nl[0]);
        e.level2 = 4'(nl[1]);
        e.state1 = 2'(st[0]);
        e.state2 = 2'(st[1]);
        e.busy = (st[0] % 2 == 1) || (st[1] % 2 == 1);
        sb_q.push_back(e);
        m_cnt = (m_cnt + 1) % 16;
        if (!h) m_presc = (m_presc + 1) % 4;
        m_lvl[0] = nl[0];
        m_lvl[1] = nl[1];
        @(posedge clk);
        #1;
        got = {pwm1, pwm2, level1, level2, state1, state2, busy};
        e = sb_q.pop_front();
        chk("scoreboard", int'(got), int'(e));
    endtask

    task automatic tick_b(input bit r1, input bit r2);
        b_req1 = r1;
        b_req2 = r2;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [7];
    int   hi_cnt;

    initial begin
        vecs[0] = '{1,  1, 0, 0, 0,  RISE, 1};
        vecs[1] = '{3,  1, 0, 0, 1,  RISE, 1};
        vecs[2] = '{24, 1, 0, 0, 7,  RISE, 1};
        vecs[3] = '{1,  0, 0, 0, 7,  FALL, 1};
        vecs[4] = '{27, 0, 0, 0, 0,  OFF,  0};
        vecs[5] = '{59, 1, 0, 0, 14, RISE, 1};
        vecs[6] = '{1,  1, 0, 0, 15, ON,   0};

        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_level1", int'(level1), 0);
        chk("reset_state1", int'(state1), OFF);
        chk("reset_busy", int'(busy), 0);

        // Ramp milestones: rise to 7, reverse, fall to 0, full rise to 15
        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < vecs[i].n; k++) tick_a(vecs[i].r1, vecs[i].r2, vecs[i].h);
            chk($sformatf("vec%0d_level1", i), int'(level1), vecs[i].lvl);
            chk($sformatf("vec%0d_state1", i), int'(state1), vecs[i].st);
            chk($sformatf("vec%0d_busy", i), int'(busy), vecs[i].bsy);
        end

        // Full brightness: pin stays high across two whole PWM periods
        tick_a(1, 0, 0);
        hi_cnt = 0;
        for (int k = 0; k < 32; k++) begin
            tick_a(1, 0, 0);
            if (pwm1) hi_cnt++;
        end
        chk("full_on_pwm_high", hi_cnt, 32);

        // Asynchronous reset between clock edges clears everything at once
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_pwm1", int'(pwm1), 0);
        chk("async_rst_level1", int'(level1), 0);
        chk("async_rst_state1", int'(state1), OFF);
        chk("async_rst_busy", int'(busy), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Level 0 under hold: never high
        hi_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            tick_a(0, 0, 1);
            if (pwm1) hi_cnt++;
        end
        chk("level0_duty", hi_cnt, 0);

        // Rise to 4, then hold for 40 clks: duty 4/16 while frozen
        for (int k = 0; k < 16; k++) tick_a(1, 0, 0);
        chk("pre_hold_level1", int'(level1), 4);
        hi_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick_a(1, 0, 1);
            if (k < 32 && pwm1) hi_cnt++;
        end
        chk("hold_duty_4of16", hi_cnt, 8);
        chk("hold_level1", int'(level1), 4);
        for (int k = 0; k < 3; k++) tick_a(1, 0, 0);
        chk("resume_level1_3clk", int'(level1), 4);
        tick_a(1, 0, 0);
        chk("resume_level1_4clk", int'(level1), 5);

        // RAMP_DIV=1: both channels together, then only channel 1 falls
        for (int k = 0; k < 14; k++) tick_b(1, 1);
        chk("b_level1_14", int'(b_level1), 14);
        chk("b_level2_14", int'(b_level2), 14);
        chk("b_state1_rise", int'(b_state1), RISE);
        chk("b_busy_rising", int'(b_busy), 1);
        tick_b(1, 1);
        chk("b_level1_15", int'(b_level1), 15);
        chk("b_level2_15", int'(b_level2), 15);
        chk("b_state2_on", int'(b_state2), ON);
        chk("b_busy_at_on", int'(b_busy), 0);
        tick_b(0, 1);
        chk("b_level1_fall", int'(b_level1), 14);
        chk("b_state1_fall", int'(b_state1), FALL);
        chk("b_level2_kept", int'(b_level2), 15);
        chk("b_busy_falling", int'(b_busy), 1);
        for (int k = 0; k < 14; k++) tick_b(0, 1);
        chk("b_level1_off", int'(b_level1), 0);
        chk("b_state1_off", int'(b_state1), OFF);
        chk("b_busy_idle", int'(b_busy), 0);

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
